// File: rtl/video_pkg.sv
// Shared definitions for the video frame writer: FSM state type and default
// geometry of one frame bank.
package video_pkg;

  // One bank holds exactly one frame; the RAM is sized by this cell count.
  localparam int VIDEO_MEM_CELL_COUNT = 3600;

  localparam int VIDEO_WORD_W      = 8;
  localparam int VIDEO_ADDR_W      = 12;
  localparam int VIDEO_FRAME_WORDS = VIDEO_MEM_CELL_COUNT;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SWAP      = 2'd1,
    WAIT_BANK = 2'd2
  } wr_state_t;

endpackage

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: shifts accepted bits in MSB first and emits a
// one-cycle word_valid with the completed word after every WORD_W bits.
module bit_packer
  import video_pkg::*;
#(
  parameter int WORD_W = VIDEO_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              bit_in,
  output logic              last_bit,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg_reg;
  logic [WORD_W-1:0] shreg_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [WORD_W-1:0] word_reg;
  logic              word_valid_reg;

  assign shreg_next[0] = bit_in;

  genvar gi;
  generate
    for (gi = 1; gi < WORD_W; gi++) begin : g_shift
      assign shreg_next[gi] = shreg_reg[gi-1];
    end
  endgenerate

  // Combinational so the parent can capture the address on the same edge.
  assign last_bit = (bit_cnt_reg == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        shreg_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (enable) begin
        shreg_reg <= shreg_next;
        if (last_bit) begin
          word_reg       <= shreg_next;
          word_valid_reg <= 1'b1;
          bit_cnt_reg    <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign word_valid = word_valid_reg;
  assign word       = word_reg;

endmodule

// File: rtl/video_frame_writer.sv
// Writes the deserialized video stream into a ping-pong frame RAM and hands
// each completed bank to the display, stalling while the display owns it.
module video_frame_writer
  import video_pkg::*;
#(
  parameter int WORD_W      = VIDEO_WORD_W,
  parameter int ADDR_W      = VIDEO_ADDR_W,
  parameter int FRAME_WORDS = VIDEO_FRAME_WORDS
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              data_clk_rising_edge,
  input  logic              video_data_ready,
  input  logic              received_bit,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_done,
  output logic              display_bank,
  output logic              overrun
);

  wr_state_t state_reg;
  wr_state_t state_next;

  logic [ADDR_W-1:0] word_addr_reg;
  logic [ADDR_W:0]   wr_addr_reg;
  logic              write_bank_reg;
  logic              display_bank_reg;
  logic              bank_free_reg;
  logic              frame_done_reg;
  logic              overrun_reg;

  logic strobe;
  logic accept;
  logic last_bit;
  logic word_done;
  logic frame_end;
  logic do_swap;

  assign strobe    = data_clk_rising_edge && video_data_ready;
  assign accept    = strobe && (state_reg == FILL);
  assign word_done = accept && last_bit;
  assign frame_end = word_done && (word_addr_reg == ADDR_W'(FRAME_WORDS - 1));

  bit_packer #(
    .WORD_W (WORD_W)
  ) u_bit_packer (
    .clk        (CLK_40),
    .rst_n      (reset_n),
    .enable     (accept),
    .clear      (do_swap),
    .bit_in     (received_bit),
    .last_bit   (last_bit),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // A WAIT_BANK exit swaps on the ack edge so frame_done follows the ack by
  // one cycle; the SWAP cycle after it (frame_done high) is only a holdoff.
  always_comb begin
    state_next = state_reg;
    do_swap    = 1'b0;
    case (state_reg)
      FILL: begin
        if (frame_end) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        if (frame_done_reg) begin
          state_next = FILL;
        end else if (bank_free_reg || frame_ack) begin
          do_swap    = 1'b1;
          state_next = FILL;
        end else begin
          state_next = WAIT_BANK;
        end
      end
      WAIT_BANK: begin
        if (frame_ack) begin
          do_swap    = 1'b1;
          state_next = SWAP;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      word_addr_reg    <= '0;
      wr_addr_reg      <= '0;
      write_bank_reg   <= 1'b0;
      display_bank_reg <= 1'b1;
      bank_free_reg    <= 1'b1;
      frame_done_reg   <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      frame_done_reg <= do_swap;

      if (strobe && (state_reg != FILL)) begin
        overrun_reg <= 1'b1;
      end

      if (word_done) begin
        wr_addr_reg   <= {write_bank_reg, word_addr_reg};
        word_addr_reg <= word_addr_reg + ADDR_W'(1);
      end

      // A swap consumes any ack arriving in the same cycle.
      if (do_swap) begin
        display_bank_reg <= write_bank_reg;
        write_bank_reg   <= ~write_bank_reg;
        bank_free_reg    <= 1'b0;
        word_addr_reg    <= '0;
      end else if (frame_ack) begin
        bank_free_reg <= 1'b1;
      end
    end
  end

  assign wr_addr      = wr_addr_reg;
  assign frame_done   = frame_done_reg;
  assign display_bank = display_bank_reg;
  assign overrun      = overrun_reg;

endmodule
